piso_shift_out: RTL and testbench

Parallel-in/serial-out shift register with a load handshake and a stallable serial output. It is the transmit end of the serial chain: it accepts a WIDTH-bit word in one cycle and presents it one bit per accepted cycle on a single wire. It sits between a parallel producer and any bit-serial consumer, such as a serial-in delay/capture chain. It uses one clock, with explicit valid/ready on the load side and a consumer enable on the serial side.

---
 rtl/piso_shift_out_if.sv | 24 ++
 rtl/piso_shift_out.sv | 98 +++++++++
 tb/tb_piso_shift_out.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/piso_shift_out_if.sv
// Load handshake and serial-output bundle for piso_shift_out.
// The master side is the producer/consumer pair; the slave side is the shifter.
interface piso_shift_out_if #(
  parameter int WIDTH = 8
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_en;
  logic             busy;
  logic             done;

  modport master (
    output load_valid, load_data, ser_en,
    input  load_ready, ser_out, ser_valid, busy, done
  );

  modport slave (
    input  load_valid, load_data, ser_en,
    output load_ready, ser_out, ser_valid, busy, done
  );
endinterface

// File: rtl/piso_shift_out.sv
// Parallel-in/serial-out shifter: accepts one WIDTH-bit word while idle and
// presents it one bit per consumer-accepted cycle, then pulses done.
// Every output comes straight from a flop, so no input reaches an output
// within the same cycle.
module piso_shift_out #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input logic             clk,
  input logic             rst,
  piso_shift_out_if.slave bus
);

  localparam int                 CNT_W = ($clog2(WIDTH) > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0]   LAST  = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;
  logic             r_ready;
  logic             r_valid;
  logic             r_busy;

  logic [WIDTH-1:0] w_shifted;
  logic             w_lastBit;

  // Next shift-register value when the consumer takes a bit: move the
  // following bit into the output position and zero-fill behind it.
  assign w_shifted = (MSB_FIRST != 0) ? {r_shreg[WIDTH-2:0], 1'b0}
                                      : {1'b0, r_shreg[WIDTH-1:1]};
  assign w_lastBit = (r_cnt == LAST);

  // Control FSM, datapath and the registered status outputs in one block;
  // ready/valid/busy always change together with the state they mirror.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.load_valid) begin
            r_shreg <= bus.load_data;
            r_cnt   <= '0;
            r_state <= SHIFT;
            r_ready <= 1'b0;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        SHIFT: begin
          if (bus.ser_en) begin
            if (w_lastBit) begin
              r_shreg <= '0;
              r_cnt   <= '0;
              r_state <= IDLE;
              r_done  <= 1'b1;
              r_ready <= 1'b1;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
            end else begin
              r_shreg <= w_shifted;
              r_cnt   <= r_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_shreg <= '0;
          r_cnt   <= '0;
          r_ready <= 1'b1;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // The shift register is zero while idle, so the output bit reads 0 there.
  assign bus.ser_out    = (MSB_FIRST != 0) ? r_shreg[WIDTH-1] : r_shreg[0];
  assign bus.ser_valid  = r_valid;
  assign bus.load_ready = r_ready;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;

endmodule

// File: tb/tb_piso_shift_out.sv
// Testbench for piso_shift_out: a table of per-edge vectors drives the
// MSB-first instance; a hand-written sequence drives an LSB-first instance.
// Output bundle order everywhere: {ser_out, ser_valid, load_ready, busy, done}.
module tb_piso_shift_out;

  localparam logic [4:0] O_IDLE = 5'b00100;
  localparam logic [4:0] O_DONE = 5'b00101;
  localparam logic [4:0] O_BIT1 = 5'b11010;
  localparam logic [4:0] O_BIT0 = 5'b01010;

  typedef struct {
    logic       rstIn;
    logic       loadValid;
    logic [7:0] loadData;
    logic       serEn;
    logic [4:0] expOut;
  } vec_t;

  logic clk;
  logic rst;
  int   checkCount;
  int   errorCount;
  vec_t vecs[$];

  piso_shift_out_if #(.WIDTH(8)) busA ();
  piso_shift_out_if #(.WIDTH(8)) busB ();

  piso_shift_out #(.WIDTH(8), .MSB_FIRST(1)) dutA (
    .clk (clk),
    .rst (rst),
    .bus (busA.slave)
  );

  piso_shift_out #(.WIDTH(8), .MSB_FIRST(0)) dutB (
    .clk (clk),
    .rst (rst),
    .bus (busB.slave)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic addVec(input logic r, input logic lv, input logic [7:0] d,
                        input logic en, input logic [4:0] exp);
    vec_t v;
    v.rstIn     = r;
    v.loadValid = lv;
    v.loadData  = d;
    v.serEn     = en;
    v.expOut    = exp;
    vecs.push_back(v);
  endtask

  // Adds vectors for the bits after the first one, taken with ser_en = 1.
  task automatic addBits(input logic [7:0] word, input int first, input logic lv,
                         input logic [7:0] d);
    for (int i = first; i >= 0; i--)
      addVec(1'b0, lv, d, 1'b1, word[i] ? O_BIT1 : O_BIT0);
  endtask

  task automatic checkOutput(input string name, input logic [4:0] act,
                             input logic [4:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got out/valid/ready/busy/done=%b expected %b",
               name, act, exp);
    end
  endtask

  // Drives one vector before an edge and samples the outputs 1 unit after it.
  task automatic applyStimulus(input vec_t v, input int idx);
    rst             = v.rstIn;
    busA.load_valid = v.loadValid;
    busA.load_data  = v.loadData;
    busA.ser_en     = v.serEn;
    @(posedge clk);
    #1;
    checkOutput($sformatf("vecA[%0d]", idx),
                {busA.ser_out, busA.ser_valid, busA.load_ready, busA.busy, busA.done},
                v.expOut);
  endtask

  task automatic stepB(input logic lv, input logic [7:0] d, input logic en,
                       input logic [4:0] exp, input string name);
    busB.load_valid = lv;
    busB.load_data  = d;
    busB.ser_en     = en;
    @(posedge clk);
    #1;
    checkOutput(name,
                {busB.ser_out, busB.ser_valid, busB.load_ready, busB.busy, busB.done},
                exp);
  endtask

  initial begin
    checkCount      = 0;
    errorCount      = 0;
    rst             = 1'b1;
    busA.load_valid = 1'b0;
    busA.load_data  = 8'h00;
    busA.ser_en     = 1'b0;
    busB.load_valid = 1'b0;
    busB.load_data  = 8'h00;
    busB.ser_en     = 1'b0;

    // Reset for two edges with a pending load that must be ignored.
    addVec(1'b1, 1'b1, 8'hA5, 1'b0, O_IDLE);
    addVec(1'b1, 1'b1, 8'hA5, 1'b0, O_IDLE);
    addVec(1'b0, 1'b0, 8'hA5, 1'b0, O_IDLE);

    // Plain word 0xA5, ser_en held high: 1,0,1,0,0,1,0,1 then done.
    addVec(1'b0, 1'b1, 8'hA5, 1'b1, O_BIT1);
    addBits(8'hA5, 6, 1'b0, 8'h00);
    addVec(1'b0, 1'b0, 8'h00, 1'b1, O_DONE);
    addVec(1'b0, 1'b0, 8'h00, 1'b1, O_IDLE);

    // Stall for three edges while the third bit (1) is presented.
    addVec(1'b0, 1'b1, 8'hA5, 1'b1, O_BIT1);
    addVec(1'b0, 1'b0, 8'h00, 1'b1, O_BIT0);
    addVec(1'b0, 1'b0, 8'h00, 1'b1, O_BIT1);
    for (int i = 0; i < 3; i++)
      addVec(1'b0, 1'b0, 8'h00, 1'b0, O_BIT1);
    addBits(8'hA5, 4, 1'b0, 8'h00);
    addVec(1'b0, 1'b0, 8'h00, 1'b1, O_DONE);
    addVec(1'b0, 1'b0, 8'h00, 1'b1, O_IDLE);

    // Back-to-back with load_valid held; data changes mid-word are ignored.
    addVec(1'b0, 1'b1, 8'hA5, 1'b1, O_BIT1);
    addBits(8'hA5, 6, 1'b1, 8'h3C);
    addVec(1'b0, 1'b1, 8'h3C, 1'b1, O_DONE);
    addVec(1'b0, 1'b1, 8'h3C, 1'b1, O_BIT0);
    addBits(8'h3C, 6, 1'b0, 8'h00);
    addVec(1'b0, 1'b0, 8'h00, 1'b1, O_DONE);

    // Reset while the fourth bit is presented, then a word of all ones.
    addVec(1'b0, 1'b1, 8'hA5, 1'b1, O_BIT1);
    addBits(8'hA5, 6, 1'b0, 8'h00);
    vecs = vecs[0:vecs.size()-5];
    addVec(1'b1, 1'b0, 8'h00, 1'b1, O_IDLE);
    addVec(1'b0, 1'b0, 8'h00, 1'b1, O_IDLE);
    addVec(1'b0, 1'b0, 8'h00, 1'b1, O_IDLE);
    addVec(1'b0, 1'b1, 8'hFF, 1'b1, O_BIT1);
    addBits(8'hFF, 6, 1'b0, 8'h00);
    addVec(1'b0, 1'b0, 8'h00, 1'b1, O_DONE);
    addVec(1'b0, 1'b0, 8'h00, 1'b1, O_IDLE);

    for (int i = 0; i < vecs.size(); i++)
      applyStimulus(vecs[i], i);

    // LSB-first instance: 0x01 emits a single 1 followed by seven 0s.
    rst = 1'b0;
    stepB(1'b1, 8'h01, 1'b1, O_BIT1, "lsbFirstBit");
    for (int i = 1; i < 8; i++)
      stepB(1'b0, 8'h00, 1'b1, O_BIT0, $sformatf("lsbBit%0d", i));
    stepB(1'b0, 8'h00, 1'b1, O_DONE, "lsbDone");
    stepB(1'b0, 8'h00, 1'b1, O_IDLE, "lsbIdle");

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
